mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control unit for the ARM processor: one FSM sequences a shared-memory datapath (single ALU, instruction/data register, ALUOut register) through fetch, decode and execute steps. It decodes Instr[31:12] and evaluates condition codes against internally held NZCV flags. It produces every datapath enable and mux select. It replaces the single-cycle control path when the core is built with a unified memory.

## Interface
Parameters: none.
- clk  in  1  core clock, all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- Instr  in  20  Instr[31:12] from the instruction register
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle
- MemReady  in  1  memory access complete; used only with MC_CTRL_MEMWAIT_EN
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=Result
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register enable
- ResultSrc  out  2  00=ALUOut, 01=ReadData, 10=ALUResult
- ALUSrcA  out  1  0=RD1 register, 1=PC
- ALUSrcB  out  2  00=WriteData, 01=ExtImm, 10=constant 4
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR
- ImmSrc  out  2  equals Instr[27:26]
- RegSrc  out  2  [0]=Op==10 (branch); [1]=Op==01 (memory)
- RegWrite  out  1  register file write enable

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE: Op=01 → MEMADR; Op=00 with Funct[5]=0 → EXECR; Op=00 with Funct[5]=1 → EXECI; Op=10 → BRANCH; Op=11 → FETCH (NOP).
  - MEMADR: Funct[0]=1 → MEMRD, else MEMWR.
  - MEMRD→MEMWB.
  - EXECR/EXECI→ALUWB.
  - MEMWB, MEMWR, ALUWB, BRANCH → FETCH.
- Per-state outputs (outputs not listed are 0):
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALU ADD, ResultSrc=10, IRWrite=1, PCWrite=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ADD.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECR: ALUSrcB=00, decoded op.
  - EXECI: ALUSrcB=01, decoded op.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcB=01, ADD, ResultSrc=10, Branch=1.
- Decode of Cmd=Instr[24:21]:
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR; any other Cmd → ADD.
  - Memory instructions: ADD if U=1, SUB if U=0.
- Flag writes (Funct[0]=S): FlagW=00 when S=0; ADD/SUB → FlagW=11; AND/ORR → FlagW=10.
- Condition logic:
  - CondEx is evaluated from Instr[31:28] and the stored Flags, then registered at the end of DECODE.
  - Condition codes: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL; 1111 → CondEx=0.
- Gating:
  - RegWrite = RegW & CondEx; MemWrite = MemW & CondEx.
  - PCWrite = NextPC | (Branch & CondEx).
  - A failed condition still walks the full state path, with no architectural writes.
- Flag update:
  - In EXECR/EXECI, when CondEx=1: FlagW[1] loads N,Z from ALUFlags[3:2]; FlagW[0] loads C,V from ALUFlags[1:0].
- Data-processing writes to R15 are out of scope; they behave as ordinary register writes.

## Timing
- Outputs are combinational from state, Instr and CondEx; no output registers.
- Latency in cycles: LDR 5, STR 4, data-processing 4, B 3, Op=11 2 (without wait states).
- Reset (reset=0):
  - State=FETCH, Flags=0000, CondEx=0.
  - PCWrite, IRWrite, RegWrite and MemWrite are forced to 0.
  - Selects take their FETCH values.
- Reset release: the first rising edge with reset=1 performs a fetch.
- Reset asserted mid-instruction aborts immediately; the next state is FETCH with no further writes.

## Configuration
- MC_CTRL_MEMWAIT_EN defined:
  - FETCH, MEMRD and MEMWR hold while MemReady=0.
  - In FETCH, IRWrite and PCWrite assert only in the MemReady=1 cycle.
  - In MEMWR, MemWrite is held for every wait cycle.
  - Each wait cycle adds one cycle to latency.
- Undefined: MemReady is ignored and every access completes in one cycle.

## Structure
- mc_ctrl_pkg holds:
  - state enum statetype_t (4-bit);
  - ALUControl constants ALU_ADD/SUB/AND/ORR;
  - Cmd and condition-code localparams;
  - ResultSrc and ALUSrcB encodings.
- Sub-module mc_condlogic contains the Flags register, the condition check, the CondEx register and write gating.
- The FSM and instruction decode stay in mc_controller.

## Test plan
- Reset held 3 cycles, then released → outputs at FETCH values with all enables 0 during reset; IRWrite=PCWrite=1 on the first cycle after release.
- ADDS (cond 1110, Funct=101001), ALUFlags=0100 in EXECI → states FETCH, DECODE, EXECI, ALUWB; ALUControl=000; RegWrite=1 in ALUWB; Flags=0100.
- Z=1 stored, then SUBNE → RegWrite=0 in ALUWB; Flags unchanged at 0100.
- LDR with U=0 → MEMADR ALUControl=001; MEMRD AdrSrc=1; MEMWB ResultSrc=01, RegWrite=1; 5 cycles total.
- BEQ with Z=1 → PCWrite=1 in BRANCH; with Z=0 → PCWrite=0; both take 3 cycles.
- MC_CTRL_MEMWAIT_EN, STR with MemReady low for 2 MEMWR cycles → MemWrite=1 for 3 cycles; FETCH entered after MemReady=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
package mc_ctrl_pkg;

  // FSM states of the multicycle sequencer
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } statetype_t;

  // ALUControl encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  // Data-processing Cmd field (Instr[24:21])
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Op field (Instr[27:26])
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Condition field (Instr[31:28])
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Evaluate a condition code against stored {N,Z,C,V}; 1111 never executes
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, r;
    {n, z, c, v} = nzcv;
    r = 1'b0;
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = c;
      COND_CC: r = ~c;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~(c & ~z);
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_condlogic.sv
// Condition unit: NZCV flag register, condition check, CondEx register and
// gating of the architectural write enables.
module mc_condlogic
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       CondLatch,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NextPC,
  input  logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       PCWrite
);

  logic [3:0] flags_q;
  logic       condex_q;

  // Flags load per half from the ALU, only for instructions whose condition passed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= 4'b0000;
    end else begin
      if (FlagW[1] && condex_q) flags_q[3:2] <= ALUFlags[3:2];
      if (FlagW[0] && condex_q) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  // CondEx is captured at the end of DECODE and held for the rest of the instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      condex_q <= 1'b0;
    end else if (CondLatch) begin
      condex_q <= cond_holds(Cond, flags_q);
    end
  end

  // Write enables are suppressed by a failed condition and while reset is held
  always_comb begin
    RegWrite = reset & RegW & condex_q;
    MemWrite = reset & MemW & condex_q;
    PCWrite  = reset & (NextPC | (Branch & condex_q));
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: sequencing FSM and instruction decode.
// Optional build macro MC_CTRL_MEMWAIT_EN: FETCH, MEMRD and MEMWR stall
// until MemReady=1; otherwise MemReady is ignored.
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        RegWrite
);

  statetype_t state_q, state_d;

  // Instr holds bits [31:12]; index n here is architectural bit n+12
  logic [3:0] cond;
  logic [1:0] op;
  logic       funct_i;
  logic [3:0] cmd;
  logic       funct_u;
  logic       funct_s;
  logic       mem_ok;
  logic       unused_bits;

  assign cond    = Instr[19:16];
  assign op      = Instr[15:14];
  assign funct_i = Instr[13];
  assign cmd     = Instr[12:9];
  assign funct_u = Instr[11];
  assign funct_s = Instr[8];

  assign ImmSrc = op;
  assign RegSrc = {op == OP_MEM, op == OP_BR};

`ifdef MC_CTRL_MEMWAIT_EN
  assign mem_ok      = MemReady;
  assign unused_bits = ^Instr[7:0];
`else
  assign mem_ok      = 1'b1;
  assign unused_bits = ^{Instr[7:0], MemReady};
`endif

  logic [2:0] alu_dp;
  logic [1:0] flagw_dp;

  // Data-processing ALU op and flag-write mask from Cmd and S
  always_comb begin
    alu_dp   = ALU_ADD;
    flagw_dp = 2'b00;
    case (cmd)
      CMD_ADD: alu_dp = ALU_ADD;
      CMD_SUB: alu_dp = ALU_SUB;
      CMD_AND: alu_dp = ALU_AND;
      CMD_ORR: alu_dp = ALU_ORR;
      default: alu_dp = ALU_ADD;
    endcase
    if (funct_s) begin
      flagw_dp = ((alu_dp == ALU_AND) || (alu_dp == ALU_ORR)) ? 2'b10 : 2'b11;
    end
  end

  // State register; reset aborts any instruction back to FETCH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = funct_i ? S_EXECI : S_EXECR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = funct_s ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ok ? S_FETCH : S_MEMWR;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_MEMWB,
      S_ALUWB,
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  logic       regw, memw, irw, nextpc, branch, cond_latch;
  logic [1:0] flag_w;

  // Per-state datapath controls (ungated enables)
  always_comb begin
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_WD;
    ALUControl = ALU_ADD;
    regw       = 1'b0;
    memw       = 1'b0;
    irw        = 1'b0;
    nextpc     = 1'b0;
    branch     = 1'b0;
    flag_w     = 2'b00;
    cond_latch = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        irw       = mem_ok;
        nextpc    = mem_ok;
      end
      S_DECODE: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        cond_latch = 1'b1;
      end
      S_MEMADR: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = funct_u ? ALU_ADD : ALU_SUB;
      end
      S_MEMRD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_READDATA;
        regw      = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        memw   = 1'b1;
      end
      S_EXECR: begin
        ALUControl = alu_dp;
        flag_w     = flagw_dp;
      end
      S_EXECI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = alu_dp;
        flag_w     = flagw_dp;
      end
      S_ALUWB: regw = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // IRWrite is not conditional, only forced low during reset
  assign IRWrite = reset & irw;

  mc_condlogic u_cond (
    .clk       (clk),
    .reset     (reset),
    .Cond      (cond),
    .ALUFlags  (ALUFlags),
    .FlagW     (flag_w),
    .CondLatch (cond_latch),
    .RegW      (regw),
    .MemW      (memw),
    .NextPC    (nextpc),
    .Branch    (branch),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .PCWrite   (PCWrite)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: checks the full output vector every cycle.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0]  ALUControl;
  logic [16:0] outv;

  int total = 0;
  int bad   = 0;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .RegWrite   (RegWrite)
  );

  always #5 clk = ~clk;

  assign outv = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                 ALUControl, ImmSrc, RegSrc, RegWrite};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Expected output vector; ImmSrc/RegSrc follow the Op of the current Instr
  function automatic logic [16:0] o(input logic pcw, input logic adr, input logic memw,
                                    input logic irw, input logic [1:0] rs, input logic asa,
                                    input logic [1:0] asb, input logic [2:0] alu,
                                    input logic rw);
    logic [1:0] op;
    op = Instr[15:14];
    return {pcw, adr, memw, irw, rs, asa, asb, alu, op, op == 2'b01, op == 2'b10, rw};
  endfunction

  function automatic logic [16:0] sF();
    return o(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 2'b10, 3'b000, 1'b0);
  endfunction
  function automatic logic [16:0] sFwait();
    return o(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 3'b000, 1'b0);
  endfunction
  function automatic logic [16:0] sD();
    return o(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 3'b000, 1'b0);
  endfunction
  function automatic logic [16:0] sRst();
    return o(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 3'b000, 1'b0);
  endfunction
  function automatic logic [16:0] sMA(input logic [2:0] alu);
    return o(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, alu, 1'b0);
  endfunction
  function automatic logic [16:0] sMR();
    return o(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0);
  endfunction
  function automatic logic [16:0] sMWB(input logic rw);
    return o(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 3'b000, rw);
  endfunction
  function automatic logic [16:0] sMWR(input logic mw);
    return o(1'b0, 1'b1, mw, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0);
  endfunction
  function automatic logic [16:0] sER(input logic [2:0] alu);
    return o(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, alu, 1'b0);
  endfunction
  function automatic logic [16:0] sEI(input logic [2:0] alu);
    return o(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, alu, 1'b0);
  endfunction
  function automatic logic [16:0] sAWB(input logic rw);
    return o(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, rw);
  endfunction
  function automatic logic [16:0] sBR(input logic pcw);
    return o(pcw, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 3'b000, 1'b0);
  endfunction

  function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op,
                                     input logic [5:0] f);
    return {c, op, f, 8'h21};
  endfunction

  // One cycle: drive inputs at the falling edge, sample 1ns later, move to next falling edge
  task automatic cyc(input string tag, input logic [16:0] exp, input logic [3:0] fl,
                     input logic mr);
    ALUFlags = fl;
    MemReady = mr;
    #1;
    check(tag, {15'd0, outv}, {15'd0, exp});
    @(negedge clk);
  endtask

  task automatic do_b(input string tag, input logic [3:0] c, input logic tk);
    Instr = mk(c, 2'b10, 6'b100000);
    cyc({tag, "_fetch"}, sF(), 4'h0, 1'b1);
    cyc({tag, "_decode"}, sD(), 4'h0, 1'b1);
    cyc({tag, "_branch"}, sBR(tk), 4'h0, 1'b1);
  endtask

  task automatic do_dp(input string tag, input logic [3:0] c, input logic [5:0] f,
                       input logic [2:0] alu, input logic [3:0] fl, input logic rw);
    Instr = mk(c, 2'b00, f);
    cyc({tag, "_fetch"}, sF(), 4'h0, 1'b1);
    cyc({tag, "_decode"}, sD(), 4'h0, 1'b1);
    cyc({tag, "_exec"}, f[5] ? sEI(alu) : sER(alu), fl, 1'b1);
    cyc({tag, "_aluwb"}, sAWB(rw), 4'h0, 1'b1);
  endtask

  task automatic do_ldr(input string tag, input logic [3:0] c, input logic [5:0] f,
                        input logic [2:0] alu, input logic rw);
    Instr = mk(c, 2'b01, f);
    cyc({tag, "_fetch"}, sF(), 4'h0, 1'b1);
    cyc({tag, "_decode"}, sD(), 4'h0, 1'b1);
    cyc({tag, "_memadr"}, sMA(alu), 4'h0, 1'b1);
    cyc({tag, "_memrd"}, sMR(), 4'h0, 1'b1);
    cyc({tag, "_memwb"}, sMWB(rw), 4'h0, 1'b1);
  endtask

  initial begin
    reset    = 1'b0;
    Instr    = 20'h0;
    ALUFlags = 4'h0;
    MemReady = 1'b1;
    @(negedge clk);
    // Reset held for three cycles: FETCH selects, all enables low
    for (int i = 0; i < 3; i++) begin
      #1;
      check("reset_hold", {15'd0, outv}, {15'd0, sRst()});
      @(negedge clk);
    end
    reset = 1'b1;

    // ADDS #imm, flags from ALU = 0100 -> stored Z=1
    do_dp("adds", 4'b1110, 6'b101001, 3'b000, 4'b0100, 1'b1);
    do_b("beq_z1", 4'b0000, 1'b1);
    // SUBNES with Z=1: no register write, no flag update
    do_dp("subnes", 4'b0001, 6'b000101, 3'b001, 4'b1111, 1'b0);
    do_b("beq_still_z", 4'b0000, 1'b1);
    do_b("bmi_n0", 4'b0100, 1'b0);
    do_b("bcs_c0", 4'b0010, 1'b0);
    // ANDS writes N,Z only: ALU 1011 -> flags 1000
    do_dp("ands", 4'b1110, 6'b000001, 3'b010, 4'b1011, 1'b1);
    do_b("beq_z0", 4'b0000, 1'b0);
    do_b("bmi_n1", 4'b0100, 1'b1);
    do_b("bcs_c_kept", 4'b0010, 1'b0);
    // ORR #imm without S: flags untouched
    do_dp("orr", 4'b1110, 6'b111000, 3'b011, 4'b1111, 1'b1);
    do_b("bvs_v0", 4'b0110, 1'b0);
    // Unlisted Cmd (EOR) decodes as ADD
    do_dp("eor_as_add", 4'b1110, 6'b000010, 3'b000, 4'b0000, 1'b1);
    // LDR with U=0, and LDR with cond 1111 (never)
    do_ldr("ldr_u0", 4'b1110, 6'b010001, 3'b001, 1'b1);
    do_ldr("ldr_nv", 4'b1111, 6'b011001, 3'b000, 1'b0);

    // STR U=1 with MemReady low in MEMWR
    Instr = mk(4'b1110, 2'b01, 6'b011000);
`ifdef MC_CTRL_MEMWAIT_EN
    cyc("str_fetch_wait", sFwait(), 4'h0, 1'b0);
    cyc("str_fetch", sF(), 4'h0, 1'b1);
    cyc("str_decode", sD(), 4'h0, 1'b1);
    cyc("str_memadr", sMA(3'b000), 4'h0, 1'b1);
    cyc("str_memwr_w1", sMWR(1'b1), 4'h0, 1'b0);
    cyc("str_memwr_w2", sMWR(1'b1), 4'h0, 1'b0);
    cyc("str_memwr", sMWR(1'b1), 4'h0, 1'b1);
`else
    cyc("str_fetch", sF(), 4'h0, 1'b1);
    cyc("str_decode", sD(), 4'h0, 1'b1);
    cyc("str_memadr", sMA(3'b000), 4'h0, 1'b1);
    cyc("str_memwr", sMWR(1'b1), 4'h0, 1'b0);
`endif

    // Op=11 is a two-cycle NOP
    Instr = mk(4'b1110, 2'b11, 6'b000000);
    cyc("nop_fetch", sF(), 4'h0, 1'b1);
    cyc("nop_decode", sD(), 4'h0, 1'b1);

    // Reset in the middle of EXECR aborts; flags return to 0000
    Instr = mk(4'b1110, 2'b00, 6'b001001);
    cyc("abort_fetch", sF(), 4'h0, 1'b1);
    cyc("abort_decode", sD(), 4'h0, 1'b1);
    ALUFlags = 4'b1111;
    reset = 1'b0;
    #1;
    check("abort_in_reset", {15'd0, outv}, {15'd0, sRst()});
    @(negedge clk);
    reset = 1'b1;
    do_b("bmi_after_rst", 4'b0100, 1'b0);
    do_b("bal_after_rst", 4'b1110, 1'b1);

    Instr = mk(4'b1110, 2'b11, 6'b000000);
    cyc("final_fetch", sF(), 4'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
